solution_serializer: RTL
========================

// Module: solution_serializer
// PURPOSE
//  Transmit-side counterpart of the host→FPGA board message stream. Latches a solved board
//  (row-major cell bits plus dimensions) and emits it to the host as two-byte messages.
//  Each message is a flag byte {flag[2:0],5'b0} followed by a data byte, using the same flag
//  codes as the inbound stream. Sits between the solver's result and the UART TX byte interface.
// PARAMETERS
//  MAX_DIM   11   max columns (n) and max rows (m); MAX_DIM*MAX_DIM must be <= 128
//  CELL_W    7    width of the cell index field in AND data bytes
// PORTS
//  clk        in   1                   clock
//  rst        in   1                   synchronous reset, active-high
//  start      in   1                   one-cycle request to send; sampled only in IDLE
//  board      in   MAX_DIM*MAX_DIM     solution; cell (r,c) is bit r*n+c; 1=filled
//  n          in   4                   columns per row (line width)
//  m          in   4                   number of rows
//  byte_out   out  8                   byte to UART TX
//  valid_out  out  1                   byte_out valid
//  ready_in   in   1                   TX accepts byte this cycle
//  busy       out  1                   high from accepted start until done
//  done       out  1                   one-cycle pulse after last byte accepted (or on error)
//  err        out  1                   one-cycle pulse with done when dimensions are invalid
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; row, col and phase counters 0.
//  Transfer: a byte moves when valid_out && ready_in.
//   byte_out must hold stable while valid_out=1 and ready_in=0.
//   valid_out never drops before acceptance, except on rst.
//  Start: start=1 in IDLE latches board, n, m.
//   If n==0, m==0, n>MAX_DIM or m>MAX_DIM: pulse done and err the next cycle, emit no bytes,
//   and stay in IDLE.
//   Otherwise busy=1, and the first byte is valid the cycle after start.
//  start is ignored while busy.
//  Data encoding:
//   dimension and index bytes are {2'b00, v[4:0], 1'b0};
//   cell bytes are {idx[6:0], bit}, where idx = r*n+c.
//  States and messages (every state sends a flag byte then a data byte, phase bit toggles):
//   HDR_N    E0, enc(n)                                  -> HDR_M
//   HDR_M    E0, enc(m)                                  -> LINE_S
//   LINE_S   C0, enc(row)                                -> CELL
//   CELL     A0, {idx,bit} for col 0..n-1 in order; col wraps to 0 after n-1 -> LINE_E
//   LINE_E   20, 00; row++; row==m -> BOARD_E, else LINE_S
//   BOARD_E  00, 00                                      -> FIN
//   FIN      busy=0, done=1 for one cycle                -> IDLE
//  Byte count = 4 + m*(2*n+4) + 2; maximum 292 for 11x11.
//  State advances only on byte acceptance. The data byte of a message always follows
//  its flag byte; no other byte is interleaved.
//  Zero-wait TX (ready_in held high): one byte per cycle, no bubbles between bytes
//  or between states.
//  The latched board is immune to changes on the board, n and m inputs during transmission.
//  rst mid-transmission: valid_out=0 next cycle, return to IDLE, no done pulse.
//  idx arithmetic uses an incrementing counter (no multiplier); width CELL_W; max 120.
// TESTING
//  1. n=2,m=2,board=4'b1001, ready_in=1 -> 22 bytes:
//     E0 04 E0 04 C0 00 A0 01 A0 02 20 00 C0 02 A0 04 A0 07 20 00 00 00;
//     done pulses once.
//  2. Same board, ready_in random 30% duty -> identical byte sequence;
//     byte_out stable while stalled.
//  3. n=11,m=11, all ones -> 292 bytes; last cell byte F1 (idx 120);
//     busy high throughout.
//  4. n=0 or m=12 -> done&err pulse one cycle after start;
//     valid_out never asserted.
//  5. start pulsed and board changed mid-send -> sequence unchanged;
//     extra start produces no second frame.
//  6. rst asserted after byte 9 -> valid_out=0 next cycle;
//     a fresh start yields the full sequence from E0.

Source files
------------

// File: rtl/solution_serializer.sv
// solution_serializer: streams a latched solved board to the UART TX byte interface
// as {flag,data} byte pairs.  Revision 1.0
`default_nettype none

module solution_serializer #(
  parameter int MAX_DIM = 11,
  parameter int CELL_W  = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [MAX_DIM*MAX_DIM-1:0]   board,
  input  logic [3:0]                   n,
  input  logic [3:0]                   m,
  output logic [7:0]                   byte_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int         CELLS     = MAX_DIM * MAX_DIM;
  localparam logic [3:0] MAX_DIM_4 = 4'(MAX_DIM);

  typedef enum logic [2:0] {
    IDLE, HDR_N, HDR_M, LINE_S, CELL, LINE_E, BOARD_E, FIN
  } state_t;

  state_t               state, state_d;
  logic                 phase;
  logic [3:0]           row, col, n_q, m_q;
  logic [CELL_W-1:0]    idx;
  logic [CELLS-1:0]     board_q;
  logic                 err_q;
  logic                 dims_ok, accept, msg_end, last_col;

  function automatic logic [7:0] enc(input logic [3:0] v);
    return {3'b000, v, 1'b0};
  endfunction

  assign dims_ok  = (n != 4'd0) && (m != 4'd0) && (n <= MAX_DIM_4) && (m <= MAX_DIM_4);
  assign accept   = valid_out && ready_in;
  assign msg_end  = accept && phase;
  assign last_col = (col == n_q - 4'd1);
  assign done     = (state == FIN) || err_q;
  assign err      = err_q;

  always_comb begin
    state_d   = state;
    valid_out = 1'b0;
    busy      = 1'b0;
    byte_out  = 8'h00;
    case (state)
      IDLE: if (start && dims_ok) state_d = HDR_N;
      HDR_N: begin
        valid_out = 1'b1;
        busy      = 1'b1;
        byte_out  = phase ? enc(n_q) : 8'hE0;
        if (msg_end) state_d = HDR_M;
      end
      HDR_M: begin
        valid_out = 1'b1;
        busy      = 1'b1;
        byte_out  = phase ? enc(m_q) : 8'hE0;
        if (msg_end) state_d = LINE_S;
      end
      LINE_S: begin
        valid_out = 1'b1;
        busy      = 1'b1;
        byte_out  = phase ? enc(row) : 8'hC0;
        if (msg_end) state_d = CELL;
      end
      CELL: begin
        valid_out = 1'b1;
        busy      = 1'b1;
        byte_out  = phase ? 8'({idx, board_q[idx]}) : 8'hA0;
        if (msg_end && last_col) state_d = LINE_E;
      end
      LINE_E: begin
        valid_out = 1'b1;
        busy      = 1'b1;
        byte_out  = phase ? 8'h00 : 8'h20;
        if (msg_end) state_d = (row + 4'd1 == m_q) ? BOARD_E : LINE_S;
      end
      BOARD_E: begin
        valid_out = 1'b1;
        busy      = 1'b1;
        byte_out  = 8'h00;
        if (msg_end) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= 1'b0;
      row     <= 4'd0;
      col     <= 4'd0;
      idx     <= '0;
      n_q     <= 4'd0;
      m_q     <= 4'd0;
      board_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_d;
      err_q <= (state == IDLE) && start && !dims_ok;
      if (state == IDLE && start) begin
        board_q <= board;
        n_q     <= n;
        m_q     <= m;
        phase   <= 1'b0;
        row     <= 4'd0;
        col     <= 4'd0;
        idx     <= '0;
      end else if (accept) begin
        phase <= ~phase;
        // idx runs continuously across rows, so it always equals r*n+c
        if (phase && state == CELL) begin
          idx <= idx + 1'b1;
          col <= last_col ? 4'd0 : col + 4'd1;
        end
        if (phase && state == LINE_E) row <= row + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire
